// File: rtl/acc_sequencer.sv
// ----------------------------------------------------------------------------
// acc_sequencer
//
// Accumulator and command sequencer placed directly upstream of a
// combinational add/sub datapath. It feeds the datapath its operands and mode,
// captures sum/carry/overflow into an accumulator with status flags, and can
// repeat an ADD or SUB up to 2^CNT_W-1 times per command.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      synchronous active-low reset
//   cmdValid/cmdReady   command handshake
//   cmdOp        00 LOAD, 01 ADD, 10 SUB, 11 CLR
//   cmdData      operand for LOAD/ADD/SUB
//   cmdCount     repeat count for ADD/SUB (0 behaves as 1)
//   addA/addB/addMode   operands and mode driven to the datapath
//   addSum/addCarry/addOverflow   datapath results
//   acc          accumulator
//   flagC/V/Z/N  carry, signed overflow, zero, negative of last acc update
//   stickyV      OR of flagV since last CLR or reset
//   resValid/resReady   result handshake
// ----------------------------------------------------------------------------
module acc_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [WIDTH-1:0] cmdData,
    input  logic [CNT_W-1:0] cmdCount,
    output logic [WIDTH-1:0] addA,
    output logic [WIDTH-1:0] addB,
    output logic             addMode,
    input  logic [WIDTH-1:0] addSum,
    input  logic             addCarry,
    input  logic             addOverflow,
    output logic [WIDTH-1:0] acc,
    output logic             flagC,
    output logic             flagV,
    output logic             flagZ,
    output logic             flagN,
    output logic             stickyV,
    output logic             resValid,
    input  logic             resReady
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   remaining;
    logic               rdy_q;

    // The datapath sees the live accumulator and the latched operand, so the
    // sum sampled at each EXEC edge always reflects this cycle's acc.
    assign addA = acc;
    assign addB = operand;

    // The registered ready is forced low while reset is asserted.
    assign cmdReady = rdy_q & reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            flagC     <= 1'b0;
            flagV     <= 1'b0;
            flagZ     <= 1'b1;
            flagN     <= 1'b0;
            stickyV   <= 1'b0;
            operand   <= '0;
            remaining <= '0;
            addMode   <= 1'b0;
            resValid  <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        rdy_q <= 1'b0;
                        case (cmdOp)
                            OP_LOAD: begin
                                acc      <= cmdData;
                                flagC    <= 1'b0;
                                flagV    <= 1'b0;
                                flagZ    <= (cmdData == '0);
                                flagN    <= cmdData[WIDTH-1];
                                resValid <= 1'b1;
                                state    <= HOLD;
                            end
                            OP_CLR: begin
                                acc      <= '0;
                                flagC    <= 1'b0;
                                flagV    <= 1'b0;
                                flagZ    <= 1'b1;
                                flagN    <= 1'b0;
                                stickyV  <= 1'b0;
                                resValid <= 1'b1;
                                state    <= HOLD;
                            end
                            default: begin
                                // ADD or SUB: a zero count still performs one step.
                                operand   <= cmdData;
                                remaining <= (cmdCount == '0) ? CNT_W'(1) : cmdCount;
                                addMode   <= (cmdOp == OP_SUB);
                                state     <= EXEC;
                            end
                        endcase
                    end
                end

                EXEC: begin
                    acc       <= addSum;
                    flagC     <= addCarry;
                    flagV     <= addOverflow;
                    flagZ     <= (addSum == '0);
                    flagN     <= addSum[WIDTH-1];
                    stickyV   <= stickyV | addOverflow;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        addMode  <= 1'b0;
                        resValid <= 1'b1;
                        state    <= HOLD;
                    end
                end

                HOLD: begin
                    if (resReady) begin
                        resValid <= 1'b0;
                        rdy_q    <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    addMode  <= 1'b0;
                    resValid <= 1'b0;
                    rdy_q    <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Accumulator and command sequencer that sits directly upstream of the 16-bit add/sub datapath. It supplies that datapath's operands and mode, and captures its sum/carry/overflow into an accumulator with status flags. Commands arrive over a valid/ready handshake and can repeat an add or subtract up to 15 times. The result leaves over a second valid/ready handshake.

## Interface
- WIDTH, 16, datapath width; equals the add/sub width.
- CNT_W, 4, width of the repeat count.

- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  command accepted when cmdValid & cmdReady at an edge.
- cmdOp  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- cmdData  in  WIDTH  operand for LOAD/ADD/SUB.
- cmdCount  in  CNT_W  repeat count for ADD/SUB; 0 is treated as 1.
- addA  out  WIDTH  to add/sub inputA; always equals acc.
- addB  out  WIDTH  to add/sub inputB; the latched operand register.
- addMode  out  1  to add/sub mode; 1 only in EXEC with a latched SUB, else 0.
- addSum  in  WIDTH  from add/sub sum.
- addCarry  in  1  from add/sub carry; for SUB, 1 means no borrow.
- addOverflow  in  1  from add/sub overflow (signed).
- acc  out  WIDTH  accumulator.
- flagC, flagV, flagZ, flagN  out  1 each  carry, signed overflow, zero, negative (acc[WIDTH-1]).
- stickyV  out  1  OR of flagV since the last CLR or reset.
- resValid  out  1  result and flags valid.
- resReady  in  1  result consumed when resValid & resReady at an edge.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE: cmdReady=1, resValid=0.
  - On accept of ADD/SUB: latch cmdData into the operand register, latch op, latch remaining = (cmdCount==0 ? 1 : cmdCount); go to EXEC.
  - On accept of LOAD: acc<=cmdData, Z/N from cmdData, C=0, V=0; go to HOLD. stickyV unchanged.
  - On accept of CLR: acc<=0, Z=1, N=0, C=0, V=0, stickyV=0; go to HOLD.
- EXEC: cmdReady=0. Every edge:
  - acc<=addSum, flagC<=addCarry, flagV<=addOverflow, flagZ<=(addSum==0), flagN<=addSum[WIDTH-1].
  - stickyV<=stickyV|addOverflow.
  - remaining decrements; when remaining==1 at the edge, go to HOLD.
- HOLD: resValid=1, cmdReady=0. acc and flags are frozen. On resReady, go to IDLE.
- Commands are never overlapped. cmdValid outside IDLE is ignored. The requester holds its command until accepted.
- Arithmetic is modulo 2^WIDTH. Carry and overflow come only from the datapath and are never recomputed locally.
- The datapath is combinational. The addSum sampled at an edge reflects acc and addB from the same cycle.

## Timing
- Reset (reset_n low at an edge) puts every register in its reset state:
  - state=IDLE, acc=0, flagZ=1, flagC=flagV=flagN=0, stickyV=0, operand=0, remaining=0.
  - resValid=0; cmdReady=0 while reset_n is low.
  - addA=0, addB=0, addMode=0.
- Reset mid-EXEC or mid-HOLD abandons the command. No resValid is produced for it.
- LOAD/CLR: accept edge E0 updates acc. resValid is high in the cycle after E0.
- ADD/SUB with effective count n: accept at E0, acc updates at E1..En, resValid is high in the cycle after En. Latency is n+1 cycles from accept to resValid.
- With resReady held high, the result is consumed on the first resValid cycle. The next command can be accepted one cycle after that.
- Flags always describe the last acc update only. Intermediate flags during EXEC are visible on the outputs but are not qualified by resValid.

## Test plan
- Reset, then LOAD 0x1234 → resValid one cycle after accept; acc=0x1234, Z=0, N=0, C=0, V=0; cmdReady=0 until resReady.
- LOAD 0x0005, then SUB 0x0002 count 3 → acc steps 0x0003, 0x0001, 0xFFFF on consecutive edges; addMode=1 in EXEC; final N=1, C=0 (borrow), V=0, Z=0; resValid after the 3rd update.
- LOAD 0x7FFF, ADD 0x0001 count 1 → acc=0x8000, V=1, N=1, stickyV=1. Then ADD 0x0001 → 0x8001, V=0, stickyV=1. Then CLR → acc=0, Z=1, stickyV=0.
- LOAD 0xFFFF, ADD 0x0001 count 0 → exactly one update; acc=0x0000, C=1, Z=1, V=0.
- Result backpressure: hold resReady low 5 cycles with cmdValid high → resValid stays high; acc and flags stable; cmdReady stays 0; no command accepted until the cycle after resReady is sampled high.
- ADD 0x0001 count 8, reset_n low at the 4th EXEC edge → next cycle all outputs at reset values, state IDLE, resValid never asserted; a subsequent LOAD 0x00AA completes normally.
